// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard controller (bypass selects, result-select codes, MC FSM states).
package hazard_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10, FWD_M_ALT = 2'b11} fwd_sel_e;
  localparam logic [1:0] RS_LOAD = 2'b01;
  localparam logic [1:0] RS_ALT  = 2'b11;
  typedef enum logic {MC_IDLE = 1'b0, MC_BUSY = 1'b1} mc_state_e;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: bypass priority for one EX operand (M over W, x0 never forwarded).
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_wrt_m_i,
  input  logic              reg_wrt_w_i,
  input  logic [1:0]        rslt_src_m_i,
  output logic [1:0]        fwd_o
);
  fwd_sel_e sel;
  always_comb
    sel = (rs_e_i == '0) ? FWD_RF :
          (reg_wrt_m_i && rs_e_i == rd_m_i) ? ((rslt_src_m_i == RS_ALT) ? FWD_M_ALT : FWD_M) :
          (reg_wrt_w_i && rs_e_i == rd_w_i) ? FWD_W : FWD_RF;
  assign fwd_o = sel;
endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: load-use/forwarding hazard unit with a multi-cycle EX sequencer.
// Perf counters are built only when HZ_PERF_CNT_EN is defined; otherwise they read 0.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic [1:0]        rslt_src_e,
  input  logic [1:0]        rslt_src_m,
  input  logic              reg_wrt_e,
  input  logic              reg_wrt_m,
  input  logic              reg_wrt_w,
  input  logic              pc_src_e,
  input  logic              mc_start_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              mc_done,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt
);
  localparam int CNT_W = $clog2(MC_LAT + 1);
  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_stall, lw;
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i(rs1_e), .rd_m_i(rd_m), .rd_w_i(rd_w), .reg_wrt_m_i(reg_wrt_m),
    .reg_wrt_w_i(reg_wrt_w), .rslt_src_m_i(rslt_src_m), .fwd_o(fwd_a_e)
  );
  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i(rs2_e), .rd_m_i(rd_m), .rd_w_i(rd_w), .reg_wrt_m_i(reg_wrt_m),
    .reg_wrt_w_i(reg_wrt_w), .rslt_src_m_i(rslt_src_m), .fwd_o(fwd_b_e)
  );
  assign lw = rslt_src_e == RS_LOAD && reg_wrt_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
  // The done cycle returns to IDLE unconditionally, so a still-high mc_start_e cannot retrigger.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    mc_done  = 1'b0;
    if (state_q == MC_IDLE) begin
      if (mc_start_e && !pc_src_e) begin
        state_d  = MC_BUSY;
        cnt_d    = CNT_W'(MC_LAT - 1);
        mc_stall = 1'b1;
      end
    end else if (cnt_q != '0) begin
      mc_stall = 1'b1;
      cnt_d    = cnt_q - CNT_W'(1);
    end else begin
      mc_done = 1'b1;
      state_d = MC_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  assign stall_f = lw | mc_stall;
  assign stall_d = lw | mc_stall;
  assign stall_e = mc_stall;
  assign flush_m = mc_stall;
  assign flush_e = (lw & !mc_stall) | pc_src_e;
  assign flush_d = pc_src_e;
`ifdef HZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cyc_q, flush_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && !(&stall_cyc_q)) stall_cyc_q <= stall_cyc_q + PERF_W'(1);
      if ((flush_d || flush_e) && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cyc = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed checks of forwarding, load-use, MC sequencing, branch priority and async reset.
module tb_hazard_ctrl_mc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0] rslt_src_e, rslt_src_m;
  logic       reg_wrt_e, reg_wrt_m, reg_wrt_w, pc_src_e, mc_start_e;
  logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_done;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
  int n_chk = 0;
  int n_err = 0;
`ifdef HZ_PERF_CNT_EN
  localparam int EXP_STALLS = 4;
`else
  localparam int EXP_STALLS = 0;
`endif
  hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(4), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .rslt_src_e(rslt_src_e), .rslt_src_m(rslt_src_m),
    .reg_wrt_e(reg_wrt_e), .reg_wrt_m(reg_wrt_m), .reg_wrt_w(reg_wrt_w),
    .pc_src_e(pc_src_e), .mc_start_e(mc_start_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mc_done(mc_done),
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic clr();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {rslt_src_e, rslt_src_m} = '0;
    {reg_wrt_e, reg_wrt_m, reg_wrt_w, pc_src_e, mc_start_e} = '0;
  endtask
  initial begin
    clr();
    rst_n = 1'b0;
    #12;
    chk("rst_stall_e", stall_e, 0);
    chk("rst_mc_done", mc_done, 0);
    chk("rst_fwd_a", fwd_a_e, 0);
    chk("rst_perf_stall", perf_stall_cyc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // M alt-result forwarding on both operands, then x0 suppression
    @(negedge clk);
    rd_m = 5; reg_wrt_m = 1; rslt_src_m = 2'b11; rs1_e = 5; rs2_e = 5;
    #1;
    chk("t1_fwd_a_alt", fwd_a_e, 2'b11);
    chk("t1_fwd_b_alt", fwd_b_e, 2'b11);
    rd_m = 0; rs1_e = 0; rs2_e = 0;
    #1;
    chk("t1_fwd_a_x0", fwd_a_e, 2'b00);
    chk("t1_fwd_b_x0", fwd_b_e, 2'b00);
    // M beats W, then W alone
    @(negedge clk);
    clr();
    rd_m = 7; rd_w = 7; reg_wrt_m = 1; reg_wrt_w = 1; rs2_e = 7;
    #1;
    chk("t2_fwd_b_m", fwd_b_e, 2'b10);
    chk("t2_fwd_a_none", fwd_a_e, 2'b00);
    reg_wrt_m = 0;
    #1;
    chk("t2_fwd_b_w", fwd_b_e, 2'b01);
    // load-use on rs2_d, then rd_e=x0
    @(negedge clk);
    clr();
    rslt_src_e = 2'b01; reg_wrt_e = 1; rd_e = 3; rs2_d = 3;
    #1;
    chk("t3_stall_f", stall_f, 1);
    chk("t3_stall_d", stall_d, 1);
    chk("t3_flush_e", flush_e, 1);
    chk("t3_stall_e", stall_e, 0);
    rd_e = 0; rs2_d = 0;
    #1;
    chk("t3_x0_stall_f", stall_f, 0);
    chk("t3_x0_flush_e", flush_e, 0);
    // multi-cycle op with mc_start_e held 5 cycles
    @(negedge clk);
    clr();
    mc_start_e = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t4_stall_f_c%0d", i), stall_f, i < 4);
      chk($sformatf("t4_stall_d_c%0d", i), stall_d, i < 4);
      chk($sformatf("t4_stall_e_c%0d", i), stall_e, i < 4);
      chk($sformatf("t4_flush_m_c%0d", i), flush_m, i < 4);
      chk($sformatf("t4_mc_done_c%0d", i), mc_done, i == 4);
      @(negedge clk);
    end
    mc_start_e = 0;
    #1;
    chk("t4_no_retrigger_stall", stall_e, 0);
    chk("t4_no_retrigger_done", mc_done, 0);
    chk("t4_perf_stall", perf_stall_cyc, EXP_STALLS);
    chk("t4_perf_flush", perf_flush_cnt, 0);
    // load-use while mc op stalls: E must not be flushed until release
    @(negedge clk);
    mc_start_e = 1; rslt_src_e = 2'b01; reg_wrt_e = 1; rd_e = 3; rs1_d = 3;
    #1;
    chk("t5_flush_e_c0", flush_e, 0);
    chk("t5_stall_f_c0", stall_f, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("t5_flush_e_c%0d", k), flush_e, 0);
      chk($sformatf("t5_stall_e_c%0d", k), stall_e, 1);
    end
    @(negedge clk);
    #1;
    chk("t5_done", mc_done, 1);
    chk("t5_lw_after_release", flush_e, 1);
    chk("t5_stall_f_release", stall_f, 1);
    // branch and mc start together: branch wins, FSM stays idle
    @(negedge clk);
    clr();
    pc_src_e = 1; mc_start_e = 1;
    #1;
    chk("t5_br_flush_d", flush_d, 1);
    chk("t5_br_flush_e", flush_e, 1);
    chk("t5_br_stall_e", stall_e, 0);
    chk("t5_br_flush_m", flush_m, 0);
    @(negedge clk);
    clr();
    #1;
    chk("t5_br_idle", stall_e, 0);
    chk("t5_br_no_done", mc_done, 0);
    // async reset mid-BUSY with cnt=2
    @(negedge clk);
    mc_start_e = 1;
    @(negedge clk);
    mc_start_e = 0;
    @(negedge clk);
    #1;
    chk("t6_busy_before_rst", stall_e, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_stall_e", stall_e, 0);
    chk("t6_rst_done", mc_done, 0);
    chk("t6_rst_perf_stall", perf_stall_cyc, 0);
    chk("t6_rst_perf_flush", perf_flush_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_post_rst_idle", stall_e, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
